flow_result_writer: RTL and testbench

- Sink for the streaming flow-vector output of the Lucas-Kanade accelerator: consumes flow_u/flow_v/flow_valid beats for one frame.
- Packs each vector into a 32-bit word and stores it in an internal result RAM, addressed by arrival order (raster order).
- Maintains per-frame statistics and provides a registered host readback port.
- Control follows the accelerator's own handshake: an arm pulse starts capture, busy is held during capture, and done is a one-cycle pulse.

---
 rtl/flow_result_writer.sv | 149 ++++++++++++++
 tb/tb_flow_result_writer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/flow_result_writer.sv
// Frame sink for Lucas-Kanade flow vectors: packs {u,v} into a result RAM in
// arrival order, keeps per-frame statistics and offers a registered host read port.
module flow_result_writer #(
   parameter int FLOW_WIDTH    = 16,
   parameter int FRAME_VECTORS = 76800,
   parameter int ADDR_WIDTH    = 17
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         arm,
   input  logic signed [FLOW_WIDTH-1:0] flow_u,
   input  logic signed [FLOW_WIDTH-1:0] flow_v,
   input  logic                         flow_valid,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH-1:0]        vec_count,
   output logic [ADDR_WIDTH-1:0]        nonzero_count,
   output logic [FLOW_WIDTH-1:0]        max_abs_u,
   output logic [FLOW_WIDTH-1:0]        max_abs_v,
   output logic [15:0]                  drop_count,
   input  logic                         rd_en,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   output logic [2*FLOW_WIDTH-1:0]      rd_data,
   output logic                         rd_valid,
   output logic [0:0]                   dbg_state
);

   // Handshake: flow_valid has no backpressure; a beat is accepted only in
   // CAPTURE without arm, otherwise it is dropped and counted. rd_en at cycle N
   // yields rd_valid/rd_data at N+1.

   localparam int IDX_W = (FRAME_VECTORS > 1) ? $clog2(FRAME_VECTORS) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_VECTORS - 1);
   localparam logic [FLOW_WIDTH:0]   ABS_MAX   = {2'b00, {(FLOW_WIDTH-1){1'b1}}};

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_CAPTURE = 1'b1;

   logic [0:0]                state_q, state_d;
   logic                      done_q, done_d;
   logic [ADDR_WIDTH-1:0]     vec_count_q, vec_count_d;
   logic [ADDR_WIDTH-1:0]     nonzero_q, nonzero_d;
   logic [FLOW_WIDTH-1:0]     max_u_q, max_u_d;
   logic [FLOW_WIDTH-1:0]     max_v_q, max_v_d;
   logic [15:0]               drop_q, drop_d;
   logic [2*FLOW_WIDTH-1:0]   rd_data_q;
   logic                      rd_valid_q;

   logic                      accept;
   logic                      drop;
   logic                      last_beat;
   logic [FLOW_WIDTH-1:0]     abs_u;
   logic [FLOW_WIDTH-1:0]     abs_v;

   logic [2*FLOW_WIDTH-1:0]   mem [FRAME_VECTORS];

   // |x| formed one bit wider so the most-negative input saturates instead of wrapping.
   function automatic logic [FLOW_WIDTH-1:0] sat_abs(input logic signed [FLOW_WIDTH-1:0] x);
      logic [FLOW_WIDTH:0] ext;
      logic [FLOW_WIDTH:0] mag;
      ext = {x[FLOW_WIDTH-1], x};
      mag = ext[FLOW_WIDTH] ? -ext : ext;
      if (mag > ABS_MAX) return ABS_MAX[FLOW_WIDTH-1:0];
      return mag[FLOW_WIDTH-1:0];
   endfunction

   assign abs_u     = sat_abs(flow_u);
   assign abs_v     = sat_abs(flow_v);
   assign accept    = (state_q == ST_CAPTURE) && flow_valid && !arm;
   assign drop      = flow_valid && (arm || (state_q == ST_IDLE));
   assign last_beat = accept && (vec_count_q == LAST_ADDR);

   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      vec_count_d = vec_count_q;
      nonzero_d   = nonzero_q;
      max_u_d     = max_u_q;
      max_v_d     = max_v_q;
      drop_d      = drop_q;
      if (arm) begin
         state_d     = ST_CAPTURE;
         vec_count_d = '0;
         nonzero_d   = '0;
         max_u_d     = '0;
         max_v_d     = '0;
         drop_d      = {15'd0, flow_valid};
      end else begin
         if (accept) begin
            vec_count_d = vec_count_q + ADDR_WIDTH'(1);
            if ((flow_u != '0) || (flow_v != '0)) nonzero_d = nonzero_q + ADDR_WIDTH'(1);
            if (abs_u > max_u_q) max_u_d = abs_u;
            if (abs_v > max_v_q) max_v_d = abs_v;
            if (last_beat) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         vec_count_q <= '0;
         nonzero_q   <= '0;
         max_u_q     <= '0;
         max_v_q     <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         vec_count_q <= vec_count_d;
         nonzero_q   <= nonzero_d;
         max_u_q     <= max_u_d;
         max_v_q     <= max_v_d;
         drop_q      <= drop_d;
      end
   end

   // vec_count doubles as the write pointer; the FSM leaves CAPTURE before it can pass the end.
   always_ff @(posedge clk) begin
      if (accept) mem[vec_count_q[IDX_W-1:0]] <= {flow_u, flow_v};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= (rd_addr <= LAST_ADDR) ? mem[rd_addr[IDX_W-1:0]] : '0;
      end
   end

   assign busy          = (state_q == ST_CAPTURE);
   assign done          = done_q;
   assign vec_count     = vec_count_q;
   assign nonzero_count = nonzero_q;
   assign max_abs_u     = max_u_q;
   assign max_abs_v     = max_v_q;
   assign drop_count    = drop_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_flow_result_writer.sv
// Directed bench for flow_result_writer with a 16-vector frame.
module tb_flow_result_writer;

   localparam int FW = 16;
   localparam int FV = 16;
   localparam int AW = 5;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 arm = 1'b0;
   logic signed [FW-1:0] flow_u = '0;
   logic signed [FW-1:0] flow_v = '0;
   logic                 flow_valid = 1'b0;
   logic                 busy, done;
   logic [AW-1:0]        vec_count, nonzero_count;
   logic [FW-1:0]        max_abs_u, max_abs_v;
   logic [15:0]          drop_count;
   logic                 rd_en = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic [2*FW-1:0]      rd_data;
   logic                 rd_valid;
   logic [0:0]           dbg_state;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   flow_result_writer #(.FLOW_WIDTH(FW), .FRAME_VECTORS(FV), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .flow_u(flow_u), .flow_v(flow_v),
      .flow_valid(flow_valid), .busy(busy), .done(done), .vec_count(vec_count),
      .nonzero_count(nonzero_count), .max_abs_u(max_abs_u), .max_abs_v(max_abs_v),
      .drop_count(drop_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [FW-1:0] u, input logic [FW-1:0] v);
      flow_u = u; flow_v = v; flow_valid = 1'b1;
      step();
      flow_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic read(input logic [AW-1:0] a);
      rd_addr = a; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++; if ({busy, done, vec_count, nonzero_count} !== '0) begin bad++; $display("FAIL reset_ctl got %h want 0", {busy, done, vec_count, nonzero_count}); end
      total++; if ({max_abs_u, max_abs_v, drop_count} !== '0) begin bad++; $display("FAIL reset_stats got %h want 0", {max_abs_u, max_abs_v, drop_count}); end
      total++; if ({rd_data, rd_valid, dbg_state} !== '0) begin bad++; $display("FAIL reset_rd got %h want 0", {rd_data, rd_valid, dbg_state}); end
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++) beat(16'd1, 16'd2);
      step();
      total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL idle_drop got %0d want 3", drop_count); end
      total++; if (vec_count !== '0 || busy !== 1'b0) begin bad++; $display("FAIL idle_state got vec=%0d busy=%b want 0 0", vec_count, busy); end
   endtask

   task automatic test_full_frame();
      done_cnt = 0;
      pulse_arm();
      total++; if (busy !== 1'b1 || drop_count !== 16'd0 || vec_count !== '0) begin bad++; $display("FAIL arm_clear got busy=%b drop=%0d vec=%0d want 1 0 0", busy, drop_count, vec_count); end
      for (int i = 0; i < FV; i++) begin
         repeat ($urandom_range(0, 2)) step();
         beat(FW'(i), FW'(-i));
         if (i < FV - 1) begin
            total++; if (done !== 1'b0 || vec_count !== AW'(i + 1)) begin bad++; $display("FAIL frame_mid beat %0d got done=%b vec=%0d want 0 %0d", i, done, vec_count, i + 1); end
         end
      end
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL frame_end got done=%b busy=%b want 1 0", done, busy); end
      total++; if (vec_count !== AW'(16) || nonzero_count !== AW'(15)) begin bad++; $display("FAIL frame_counts got vec=%0d nz=%0d want 16 15", vec_count, nonzero_count); end
      total++; if (max_abs_u !== 16'd15 || max_abs_v !== 16'd15) begin bad++; $display("FAIL frame_max got u=%0d v=%0d want 15 15", max_abs_u, max_abs_v); end
      step();
      step();
      total++; if (done_cnt !== 1 || done !== 1'b0 || vec_count !== AW'(16)) begin bad++; $display("FAIL done_once got pulses=%0d done=%b vec=%0d want 1 0 16", done_cnt, done, vec_count); end
   endtask

   task automatic test_readback();
      read(AW'(5));
      total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0005_FFFB) begin bad++; $display("FAIL rd_5 got v=%b d=%h want 1 0005fffb", rd_valid, rd_data); end
      step();
      total++; if (rd_valid !== 1'b0 || rd_data !== 32'h0005_FFFB) begin bad++; $display("FAIL rd_hold got v=%b d=%h want 0 0005fffb", rd_valid, rd_data); end
      read(AW'(15));
      total++; if (rd_data !== 32'h000F_FFF1) begin bad++; $display("FAIL rd_15 got %h want 000ffff1", rd_data); end
      read(AW'(20));
      total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin bad++; $display("FAIL rd_oob got v=%b d=%h want 1 0", rd_valid, rd_data); end
   endtask

   task automatic test_saturation();
      pulse_arm();
      beat(16'h8000, 16'd100);
      total++; if (max_abs_u !== 16'd32767 || max_abs_v !== 16'd100) begin bad++; $display("FAIL sat_max got u=%0d v=%0d want 32767 100", max_abs_u, max_abs_v); end
      total++; if (nonzero_count !== AW'(1) || vec_count !== AW'(1)) begin bad++; $display("FAIL sat_counts got nz=%0d vec=%0d want 1 1", nonzero_count, vec_count); end
      beat(16'h0000, 16'hFF9C);
      total++; if (nonzero_count !== AW'(2) || max_abs_v !== 16'd100 || max_abs_u !== 16'd32767) begin bad++; $display("FAIL sat_hold got nz=%0d u=%0d v=%0d want 2 32767 100", nonzero_count, max_abs_u, max_abs_v); end
      read(AW'(0));
      total++; if (rd_data !== 32'h8000_0064) begin bad++; $display("FAIL sat_rd got %h want 80000064", rd_data); end
   endtask

   task automatic test_restart();
      done_cnt = 0;
      pulse_arm();
      for (int i = 0; i < 7; i++) beat(FW'(i + 1), FW'(i + 1));
      arm = 1'b1;
      beat(16'h7777, 16'h7777);
      arm = 1'b0;
      total++; if (vec_count !== '0 || drop_count !== 16'd1 || busy !== 1'b1) begin bad++; $display("FAIL restart got vec=%0d drop=%0d busy=%b want 0 1 1", vec_count, drop_count, busy); end
      rd_en = 1'b1; rd_addr = '0;
      beat(16'h0100, 16'h0200);
      rd_en = 1'b0;
      total++; if (rd_data !== 32'h0001_0001) begin bad++; $display("FAIL read_first got %h want 00010001", rd_data); end
      for (int i = 1; i < FV; i++) beat(FW'(16'h0100 + i), FW'(16'h0200 + i));
      total++; if (done !== 1'b1 || vec_count !== AW'(16)) begin bad++; $display("FAIL restart_end got done=%b vec=%0d want 1 16", done, vec_count); end
      read(AW'(0));
      total++; if (rd_data !== 32'h0100_0200) begin bad++; $display("FAIL restart_rd0 got %h want 01000200", rd_data); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_pulses got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid_capture();
      done_cnt = 0;
      pulse_arm();
      for (int i = 0; i < 9; i++) beat(FW'(i + 3), FW'(-(i + 3)));
      total++; if (vec_count !== AW'(9) || max_abs_v !== 16'd11) begin bad++; $display("FAIL mid_pre got vec=%0d v=%0d want 9 11", vec_count, max_abs_v); end
      rst_n = 1'b0;
      #1;
      total++; if ({busy, done, vec_count, nonzero_count, max_abs_u, max_abs_v, drop_count, dbg_state} !== '0) begin bad++; $display("FAIL mid_reset got busy=%b vec=%0d nz=%0d drop=%0d want all 0", busy, vec_count, nonzero_count, drop_count); end
      step();
      rst_n = 1'b1;
      step();
      beat(16'd4, 16'd4);
      beat(16'd4, 16'd4);
      step();
      total++; if (drop_count !== 16'd2 || busy !== 1'b0 || vec_count !== '0) begin bad++; $display("FAIL mid_idle got drop=%0d busy=%b vec=%0d want 2 0 0", drop_count, busy, vec_count); end
      total++; if (done_cnt !== 0) begin bad++; $display("FAIL mid_nodone got %0d want 0", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_readback();
      test_saturation();
      test_restart();
      test_reset_mid_capture();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
